// File: rtl/judge_ctrl.sv
// Judgement controller: qualifies key presses against two arrow lanes, strobes hits,
// drives the HIT/MISS popup and keeps score/combo. Optional max_combo: JUDGE_MAXCOMBO_EN.
module judge_ctrl #(
  parameter int WIN_LO      = 16,
  parameter int WIN_HI      = 56,
  parameter int HOLD_FRAMES = 30,
  parameter int HIT_PTS     = 10
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic [7:0] keycode,
  input  logic [3:0] spriteID_a,
  input  logic [9:0] posY_a,
  input  logic [3:0] spriteID_b,
  input  logic [9:0] posY_b,
  output logic       sprite2hit_out,
  output logic       sprite3hit_out,
  output logic [3:0] popup_id,
  output logic [9:0] popup_x,
  output logic [9:0] popup_y,
  output logic [15:0] score,
  output logic [7:0] combo,
  output logic [7:0] max_combo
);

  localparam logic [1:0]  S_APPROACH = 2'd0;
  localparam logic [1:0]  S_ARMED    = 2'd1;
  localparam logic [1:0]  S_DONE     = 2'd2;
  localparam logic [0:0]  P_IDLE     = 1'b0;
  localparam logic [0:0]  P_SHOW     = 1'b1;
  localparam logic [6:0]  WIN_LO7    = 7'(WIN_LO);
  localparam logic [6:0]  WIN_HI7    = 7'(WIN_HI);
  localparam logic [7:0]  HOLD8      = 8'(HOLD_FRAMES);
  localparam logic [16:0] PTS17      = 17'(HIT_PTS);
  localparam logic [3:0]  POP_NONE   = 4'd0;
  localparam logic [3:0]  POP_HIT    = 4'd8;
  localparam logic [3:0]  POP_MISS   = 4'd9;

  logic [1:0] valid, match, match_q, press, in_win, hit, miss;
  logic [6:0] pos7 [2];
  logic [1:0] st_q [2];
  logic [1:0] st_d [2];
  logic       unused_pos_hi;

  assign popup_x = 10'h140;
  assign popup_y = 10'h0F0;

  // Only the low seven bits of Y locate the arrow relative to the hit line.
  assign pos7[0]       = posY_a[6:0];
  assign pos7[1]       = posY_b[6:0];
  assign unused_pos_hi = ^{posY_a[9:7], posY_b[9:7]};

  assign valid[0] = (spriteID_a == 4'd4) || (spriteID_a == 4'd6);
  assign valid[1] = (spriteID_b == 4'd5) || (spriteID_b == 4'd7);
  assign match[0] = (keycode == 8'h1A && spriteID_a == 4'd4) ||
                    (keycode == 8'h04 && spriteID_a == 4'd6);
  assign match[1] = (keycode == 8'h16 && spriteID_b == 4'd5) ||
                    (keycode == 8'h07 && spriteID_b == 4'd7);
  assign press    = match & ~match_q;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      hit[i]    = 1'b0;
      miss[i]   = 1'b0;
      in_win[i] = valid[i] && (pos7[i] > WIN_LO7) && (pos7[i] < WIN_HI7);
      case (st_q[i])
        S_APPROACH: if (in_win[i]) st_d[i] = S_ARMED;
        S_ARMED: begin
          if (!valid[i]) begin
            st_d[i] = S_APPROACH;
          end else if (press[i]) begin
            st_d[i] = S_DONE;
            hit[i]  = 1'b1;
          end else if (pos7[i] >= WIN_HI7) begin
            st_d[i] = S_DONE;
            miss[i] = 1'b1;
          end
        end
        S_DONE:  if (!valid[i] || pos7[i] <= WIN_LO7) st_d[i] = S_APPROACH;
        default: st_d[i] = S_APPROACH;
      endcase
    end
  end

  function automatic logic [15:0] sat_add(input logic [15:0] s);
    logic [16:0] sum;
    sum = {1'b0, s} + PTS17;
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic [7:0] next_combo(input logic [7:0] c, input logic h, input logic m);
    if (h)      return (c == 8'hFF) ? c : c + 8'd1;
    else if (m) return 8'd0;
    else        return c;
  endfunction

  // Slot A is applied before slot B so a same-cycle hit then miss ends at combo 0.
  logic [15:0] score_a, score_b;
  logic [7:0]  combo_a, combo_b;
  assign score_a = hit[0] ? sat_add(score)   : score;
  assign score_b = hit[1] ? sat_add(score_a) : score_a;
  assign combo_a = next_combo(combo,   hit[0], miss[0]);
  assign combo_b = next_combo(combo_a, hit[1], miss[1]);

  logic       vs_s1, vs_s2, vs_s3, tick;
  logic [0:0] pop_st;
  logic [7:0] hold_cnt;
  assign tick = vs_s2 & ~vs_s3;

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      match_q        <= '0;
      st_q[0]        <= S_APPROACH;
      st_q[1]        <= S_APPROACH;
      sprite2hit_out <= 1'b0;
      sprite3hit_out <= 1'b0;
      score          <= '0;
      combo          <= '0;
      vs_s1          <= 1'b0;
      vs_s2          <= 1'b0;
      vs_s3          <= 1'b0;
      pop_st         <= P_IDLE;
      popup_id       <= POP_NONE;
      hold_cnt       <= '0;
    end else begin
      match_q        <= match;
      st_q[0]        <= st_d[0];
      st_q[1]        <= st_d[1];
      sprite2hit_out <= hit[0];
      sprite3hit_out <= hit[1];
      score          <= score_b;
      combo          <= combo_b;
      vs_s1          <= vs;
      vs_s2          <= vs_s1;
      vs_s3          <= vs_s2;
      if (|hit || |miss) begin
        pop_st   <= P_SHOW;
        popup_id <= (|hit) ? POP_HIT : POP_MISS;
        hold_cnt <= HOLD8;
      end else if (pop_st == P_SHOW && tick) begin
        if (hold_cnt <= 8'd1) begin
          pop_st   <= P_IDLE;
          popup_id <= POP_NONE;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_cnt - 8'd1;
        end
      end
    end
  end

`ifdef JUDGE_MAXCOMBO_EN
  logic [7:0] max_q, max_ab;
  assign max_ab = (combo_b > combo_a) ? combo_b : combo_a;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)            max_q <= '0;
    else if (max_ab > max_q) max_q <= max_ab;
  end
  assign max_combo = max_q;
`else
  assign max_combo = '0;
`endif

endmodule

// File: tb/tb_judge_ctrl.sv
// Self-checking bench for judge_ctrl: table of single-cycle vectors through a scoreboard queue,
// then hand-written sequences for held keys, popup hold/reload, async reset and max_combo.
module tb_judge_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        vs = 1'b0;
  logic [7:0]  keycode = '0;
  logic [3:0]  spriteID_a = '0, spriteID_b = '0;
  logic [9:0]  posY_a = '0, posY_b = '0;
  logic        sprite2hit_out, sprite3hit_out;
  logic [3:0]  popup_id;
  logic [9:0]  popup_x, popup_y;
  logic [15:0] score;
  logic [7:0]  combo, max_combo;

  int n_checks = 0;
  int n_errors = 0;

  judge_ctrl #(.WIN_LO(16), .WIN_HI(56), .HOLD_FRAMES(3), .HIT_PTS(10)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .keycode(keycode),
    .spriteID_a(spriteID_a), .posY_a(posY_a),
    .spriteID_b(spriteID_b), .posY_b(posY_b),
    .sprite2hit_out(sprite2hit_out), .sprite3hit_out(sprite3hit_out),
    .popup_id(popup_id), .popup_x(popup_x), .popup_y(popup_y),
    .score(score), .combo(combo), .max_combo(max_combo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  id_a;
    logic [9:0]  pos_a;
    logic [3:0]  id_b;
    logic [9:0]  pos_b;
    logic [7:0]  key;
    logic        sa;
    logic        sb;
    logic [3:0]  pid;
    logic [15:0] score;
    logic [7:0]  combo;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] ia, input logic [9:0] pa,
                       input logic [3:0] ib, input logic [9:0] pb, input logic [7:0] k);
    spriteID_a = ia; posY_a = pa; spriteID_b = ib; posY_b = pb; keycode = k;
  endtask

  function automatic vec_t mk(input logic [3:0] ia, input logic [9:0] pa, input logic [3:0] ib,
                              input logic [9:0] pb, input logic [7:0] k, input logic sa,
                              input logic sb, input logic [3:0] pid, input logic [15:0] sc,
                              input logic [7:0] cb);
    vec_t v;
    v.id_a = ia; v.pos_a = pa; v.id_b = ib; v.pos_b = pb; v.key = k;
    v.sa = sa; v.sb = sb; v.pid = pid; v.score = sc; v.combo = cb;
    return v;
  endfunction

  // One vs pulse long enough to pass the synchronizer and produce one tick.
  task automatic vs_pulse();
    vs = 1'b1;
    step(4);
    vs = 1'b0;
    step(4);
  endtask

  task automatic hit_a_lane();
    drive(4'd4, 10'd10, 4'd0, 10'd0, 8'h00); step();
    drive(4'd4, 10'd36, 4'd0, 10'd0, 8'h00); step();
    drive(4'd4, 10'd36, 4'd0, 10'd0, 8'h1A); step();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] exp_max;
  int         strobes, back2back;

  initial begin
    // ---- reset values ----
    #12;
    check("reset_strobe_a", sprite2hit_out, 0);
    check("reset_strobe_b", sprite3hit_out, 0);
    check("reset_popup_id", popup_id, 0);
    check("reset_score", score, 0);
    check("reset_combo", combo, 0);
    check("reset_max_combo", max_combo, 0);
    check("popup_x", popup_x, 10'h140);
    check("popup_y", popup_y, 10'h0F0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();

    //          id_a  pos_a   id_b  pos_b   key    sa sb pid score combo
    tbl.push_back(mk(4'd4, 10'd36, 4'd0, 10'd0,  8'h00, 0, 0, 0, 0,  0));
    tbl.push_back(mk(4'd4, 10'd36, 4'd0, 10'd0,  8'h1A, 1, 0, 8, 10, 1));
    tbl.push_back(mk(4'd4, 10'd36, 4'd0, 10'd0,  8'h1A, 0, 0, 8, 10, 1));
    tbl.push_back(mk(4'd4, 10'd10, 4'd0, 10'd0,  8'h00, 0, 0, 8, 10, 1));
    tbl.push_back(mk(4'd0, 10'd0,  4'd5, 10'd10, 8'h00, 0, 0, 8, 10, 1));
    tbl.push_back(mk(4'd0, 10'd0,  4'd5, 10'd30, 8'h00, 0, 0, 8, 10, 1));
    tbl.push_back(mk(4'd0, 10'd0,  4'd5, 10'd55, 8'h00, 0, 0, 8, 10, 1));
    tbl.push_back(mk(4'd0, 10'd0,  4'd5, 10'd56, 8'h00, 0, 0, 9, 10, 0));
    tbl.push_back(mk(4'd0, 10'd0,  4'd5, 10'd60, 8'h00, 0, 0, 9, 10, 0));
    tbl.push_back(mk(4'd0, 10'd0,  4'd0, 10'd0,  8'h00, 0, 0, 9, 10, 0));
    tbl.push_back(mk(4'd6, 10'd30, 4'd7, 10'd30, 8'h00, 0, 0, 9, 10, 0));
    tbl.push_back(mk(4'd6, 10'd30, 4'd7, 10'd30, 8'h07, 0, 1, 8, 20, 1));
    tbl.push_back(mk(4'd6, 10'd30, 4'd7, 10'd10, 8'h00, 0, 0, 8, 20, 1));
    tbl.push_back(mk(4'd6, 10'd30, 4'd7, 10'd30, 8'h00, 0, 0, 8, 20, 1));
    tbl.push_back(mk(4'd6, 10'd30, 4'd7, 10'd56, 8'h04, 1, 0, 8, 30, 0));
    tbl.push_back(mk(4'd6, 10'd30, 4'd0, 10'd0,  8'h00, 0, 0, 8, 30, 0));
    tbl.push_back(mk(4'd6, 10'd30, 4'd0, 10'd0,  8'h04, 0, 0, 8, 30, 0));
    tbl.push_back(mk(4'd6, 10'd10, 4'd0, 10'd0,  8'h00, 0, 0, 8, 30, 0));
    tbl.push_back(mk(4'd6, 10'd10, 4'd0, 10'd0,  8'h04, 0, 0, 8, 30, 0));
    tbl.push_back(mk(4'd6, 10'd16, 4'd0, 10'd0,  8'h00, 0, 0, 8, 30, 0));
    tbl.push_back(mk(4'd6, 10'd16, 4'd0, 10'd0,  8'h04, 0, 0, 8, 30, 0));
    tbl.push_back(mk(4'd6, 10'd17, 4'd0, 10'd0,  8'h00, 0, 0, 8, 30, 0));
    tbl.push_back(mk(4'd6, 10'd17, 4'd0, 10'd0,  8'h04, 1, 0, 8, 40, 1));
    tbl.push_back(mk(4'd0, 10'd0,  4'd5, 10'd30, 8'h00, 0, 0, 8, 40, 1));
    tbl.push_back(mk(4'd0, 10'd0,  4'd0, 10'd0,  8'h00, 0, 0, 8, 40, 1));
    tbl.push_back(mk(4'd0, 10'd0,  4'd5, 10'd56, 8'h00, 0, 0, 8, 40, 1));
    tbl.push_back(mk(4'd0, 10'd0,  4'd5, 10'd60, 8'h00, 0, 0, 8, 40, 1));

    foreach (tbl[i]) begin
      vec_t e;
      drive(tbl[i].id_a, tbl[i].pos_a, tbl[i].id_b, tbl[i].pos_b, tbl[i].key);
      exp_q.push_back(tbl[i]);
      step();
      e = exp_q.pop_front();
      check($sformatf("vec%0d_strobe_a", i), sprite2hit_out, e.sa);
      check($sformatf("vec%0d_strobe_b", i), sprite3hit_out, e.sb);
      check($sformatf("vec%0d_popup_id", i), popup_id, e.pid);
      check($sformatf("vec%0d_score", i), score, e.score);
      check($sformatf("vec%0d_combo", i), combo, e.combo);
    end

    // ---- held key: one strobe only; Y bits above [6:0] are ignored ----
    drive(4'd4, 10'h224, 4'd0, 10'd0, 8'h00); step();
    drive(4'd4, 10'h224, 4'd0, 10'd0, 8'h1A);
    strobes = 0; back2back = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (sprite2hit_out) strobes++;
      if (sprite2hit_out && strobes > 1) back2back++;
    end
    check("held_key_strobes", strobes, 1);
    check("held_key_extra", back2back, 0);
    check("held_key_score", score, 50);
    check("held_key_combo", combo, 2);

    // ---- popup hold and reload (HOLD_FRAMES = 3) ----
    vs_pulse(); vs_pulse();
    check("popup_after_2_ticks", popup_id, 8);
    hit_a_lane();
    check("reload_hit_score", score, 60);
    check("reload_hit_combo", combo, 3);
    vs_pulse(); vs_pulse();
    check("popup_after_reload_2_ticks", popup_id, 8);
    vs = 1'b1;
    step(2);
    check("tick_latency_before", popup_id, 8);
    step();
    check("tick_latency_after", popup_id, 0);
    vs = 1'b0;
    step(4);
    check("popup_stays_idle", popup_id, 0);

    // ---- asynchronous reset mid-SHOW and mid-ARMED ----
    hit_a_lane();
    check("pre_reset_score", score, 70);
    check("pre_reset_popup", popup_id, 8);
    drive(4'd4, 10'd36, 4'd5, 10'd30, 8'h1A); step();
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_popup", popup_id, 0);
    check("async_rst_score", score, 0);
    check("async_rst_combo", combo, 0);
    check("async_rst_max", max_combo, 0);
    check("async_rst_strobes", {sprite2hit_out, sprite3hit_out}, 0);
    step(2);
    #2 Reset_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (sprite2hit_out || sprite3hit_out) strobes++;
    end
    check("post_reset_no_strobe", strobes, 0);
    check("post_reset_score", score, 0);
    check("post_reset_popup", popup_id, 0);

    // ---- five hits then a miss ----
    drive(4'd0, 10'd0, 4'd0, 10'd0, 8'h00); step();
    for (int h = 0; h < 5; h++) hit_a_lane();
    check("five_hits_combo", combo, 5);
    drive(4'd0, 10'd0, 4'd5, 10'd30, 8'h00); step();
    drive(4'd0, 10'd0, 4'd5, 10'd56, 8'h00); step();
`ifdef JUDGE_MAXCOMBO_EN
    exp_max = 8'd5;
`else
    exp_max = 8'd0;
`endif
    check("miss_combo", combo, 0);
    check("miss_popup", popup_id, 9);
    check("five_hits_score", score, 50);
    check("max_combo", max_combo, exp_max);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
